// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the data-store bus.
//
// Stores to TX_ADDR queue wr_data[7:0] in a byte FIFO, and the FSM sends
// each byte as an 8N1 frame on tx. Stores to STAT_ADDR clear the sticky
// overflow flag. Loads from STAT_ADDR return the status word through
// rd_data with no latency.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   reset      - synchronous, active-high reset
//   wr_en      - store strobe from the memory-stage bus
//   wr_addr    - store address
//   wr_data    - store data; only bits [7:0] are used
//   rd_addr    - load address
//   rd_data    - {0.., overflow, tx_busy, fifo_full, fifo_empty} when
//                rd_addr == STAT_ADDR, otherwise 0
//   tx         - registered serial line, idle high
//   tx_busy    - FSM not in IDLE
//   fifo_empty - FIFO holds no bytes
//   fifo_full  - FIFO holds FIFO_DEPTH bytes
//   overflow   - sticky flag: a push was dropped because the FIFO was full
module mmio_uart_tx #(
   parameter int unsigned      WIDTH        = 32,
   parameter int unsigned      CLKS_PER_BIT = 868,
   parameter int unsigned      FIFO_DEPTH   = 16,
   parameter logic [WIDTH-1:0] TX_ADDR      = 32'h40000004,
   parameter logic [WIDTH-1:0] STAT_ADDR    = 32'h40000005
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             tx,
   output logic             tx_busy,
   output logic             fifo_empty,
   output logic             fifo_full,
   output logic             overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned BW = $clog2(CLKS_PER_BIT);
   localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   // FIFO storage and bookkeeping
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   logic push_req;
   logic clr_req;
   logic push_ok;
   logic pop;

   // Transmit FSM
   state_t        state, state_n;
   logic [BW-1:0] baud_cnt, baud_n;
   logic [2:0]    bit_idx, bit_n;
   logic [7:0]    shift, shift_n;
   logic          tx_n;
   logic          baud_last;

   assign push_req   = wr_en && (wr_addr == TX_ADDR);
   assign clr_req    = wr_en && (wr_addr == STAT_ADDR);
   // A pop in the same cycle frees a slot, so a push at full is still taken.
   assign push_ok    = push_req && (!fifo_full || pop);

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == DEPTH_CNT);
   assign tx_busy    = (state != IDLE);

   assign rd_data = (rd_addr == STAT_ADDR)
                  ? {{(WIDTH-4){1'b0}}, overflow, tx_busy, fifo_full, fifo_empty}
                  : '0;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= wr_data[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_ok && !pop) begin
            count <= count + 1'b1;
         end else if (!push_ok && pop) begin
            count <= count - 1'b1;
         end
         // A dropped push takes priority over a clear in the same cycle.
         if (push_req && !push_ok) begin
            overflow <= 1'b1;
         end else if (clr_req) begin
            overflow <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_n;
         baud_cnt <= baud_n;
         bit_idx  <= bit_n;
         shift    <= shift_n;
         tx       <= tx_n;
      end
   end

   always_comb begin
      state_n   = state;
      baud_n    = baud_cnt;
      bit_n     = bit_idx;
      shift_n   = shift;
      pop       = 1'b0;
      tx_n      = 1'b1;
      baud_last = (baud_cnt == BAUD_LAST);

      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_n = mem[rd_ptr];
               baud_n  = '0;
               bit_n   = '0;
               state_n = START;
            end
         end
         START: begin
            if (baud_last) begin
               baud_n  = '0;
               state_n = DATA;
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         DATA: begin
            if (baud_last) begin
               baud_n = '0;
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
               end else begin
                  bit_n   = bit_idx + 1'b1;
                  shift_n = {1'b0, shift[7:1]};
               end
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         STOP: begin
            if (baud_last) begin
               baud_n  = '0;
               state_n = IDLE;
            end else begin
               baud_n = baud_cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      // tx is registered from the next state so the line level changes on
      // the same edge as the state it belongs to.
      case (state_n)
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_n[0];
         default: tx_n = 1'b1;
      endcase
   end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the processor's data-store path, downstream of the memory stage. It consumes the same store bus that drives the PORT_OUT registers (`wr_en`, `wr_addr`, `wr_data`) and decodes two addresses. Bytes written to the TX address are queued in a FIFO and serialized on `tx` as 8N1 frames. A status word is returned combinationally for loads from the status address.

## Interface
- WIDTH, 32, data/address bus width
- CLKS_PER_BIT, 868, clock cycles per UART bit; must be ≥ 2
- FIFO_DEPTH, 16, byte FIFO entries; must be a power of 2 and ≥ 2
- TX_ADDR, 32'h40000004, store address that enqueues a byte
- STAT_ADDR, 32'h40000005, status address (load reads it; store clears overflow)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-high
- wr_en  in  1  store strobe from the memory-stage bus
- wr_addr  in  WIDTH  store address
- wr_data  in  WIDTH  store data; only bits [7:0] are used
- rd_addr  in  WIDTH  load address
- rd_data  out  WIDTH  status word when rd_addr==STAT_ADDR, otherwise 0 (combinational)
- tx  out  1  serial line, registered, idle high
- tx_busy  out  1  FSM not in IDLE
- fifo_empty  out  1  FIFO holds no bytes
- fifo_full  out  1  FIFO holds FIFO_DEPTH bytes
- overflow  out  1  sticky flag: a push was dropped

## Operation
- **Push:** fires when wr_en && wr_addr==TX_ADDR. It enqueues wr_data[7:0] if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the byte is discarded and overflow is set.
- **Clear overflow:** wr_en && wr_addr==STAT_ADDR clears overflow. If a dropped push and a clear occur in the same cycle, set wins. That case cannot arise from a single store, but the rule is fixed anyway.
- **Other addresses:** stores to any other address are ignored.
- **FIFO:** circular buffer with read/write pointers of log2(FIFO_DEPTH) bits, wrapping modulo FIFO_DEPTH. Occupancy counter is log2(FIFO_DEPTH)+1 bits. A simultaneous push and pop leaves the count unchanged.
- **Status word:** rd_data = {WIDTH-4 zeros, overflow, tx_busy, fifo_full, fifo_empty}. Bit 0 is fifo_empty.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: tx=1. If the FIFO is non-empty, pop the head byte into the shift register, clear the baud counter and bit index, then go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- **Baud counter:** counts 0..CLKS_PER_BIT-1. Its terminal count advances the bit or the state.
- **Output reset values:** tx=1, tx_busy=0, fifo_empty=1, fifo_full=0, overflow=0. rd_data=0 unless rd_addr==STAT_ADDR, in which case it reads 32'h1.
- **Reset mid-frame:** FSM returns to IDLE, tx=1 on the next edge, FIFO is emptied, and the in-flight byte is lost.

## Timing
- **Push visibility:** a push sampled at edge E0 makes fifo_empty=0 after E0.
- **Frame start:** at E1 the FSM pops and enters START. tx=0 and tx_busy=1 from E1.
- **Frame length:** 10·CLKS_PER_BIT cycles from E1 until the FSM returns to IDLE.
- **Back-to-back frames:** IDLE always lasts at least one cycle. Consecutive queued bytes therefore start every 10·CLKS_PER_BIT+1 cycles.
- **Flag update:** fifo_full and fifo_empty update on the edge that changes the count. A pop at the IDLE→START edge lowers the count on that same edge.
- **Read path:** rd_data has zero latency (combinational on rd_addr and the registered flags).
- **Push during STOP:** a push while in STOP is transmitted after the following IDLE cycle with no extra gap.

## Test plan
- **Single byte:** CLKS_PER_BIT=4. Store 32'h00000155 to TX_ADDR → tx stays low 4 cycles from E1, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles. tx_busy is high for 40 cycles, and fifo_empty=1 after E1.
- **Back-to-back:** store 0xA5 then 0x3C on consecutive cycles → the second start bit begins exactly 41 cycles after the first. Decoded bytes are 0xA5 then 0x3C.
- **Overflow:** FIFO_DEPTH=4, CLKS_PER_BIT=4. Store 6 bytes on consecutive cycles → the first pops at E1, so 5 are held or transmitted and 1 is dropped. overflow=1 and a status read gives bit3=1. A store to STAT_ADDR → overflow=0.
- **Address decode:** store to 32'h40000000 and 32'h40000006 → no FIFO change and tx stays 1. Load from 32'h40000004 → rd_data=0.
- **Reset mid-frame:** queue 3 bytes, assert reset during DATA bit 3 → tx=1, tx_busy=0, fifo_empty=1 after that edge, and no further frames follow.
- **Simultaneous push/pop at full:** with the FIFO full and the FSM entering IDLE, push in the pop cycle → the byte is accepted, overflow stays 0, fifo_full stays 1.
